// File: rtl/rr_decode_arbiter4.sv
// Four-way round-robin arbiter with one-hot decoded grant and a hold-time limit.
// Latency: req to gnt is one cycle; no backpressure, losing requesters just keep req high.

module dec2to4 (
  input  logic [1:0] sel,
  input  logic       en,
  output logic [3:0] y
);
  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end
endmodule

module rr_decode_arbiter4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_d;
  logic [1:0]       last_ptr, last_ptr_d;
  logic [1:0]       idx_d;
  logic             on_d;
  logic             timeout_d;
  logic [3:0]       gnt_d;
  logic [1:0]       winner;
  logic [1:0]       cand;
  logic             found;

  // Search starts one past the previous winner, so it ends up with lowest priority.
  always_comb begin
    winner = 2'd0;
    cand   = 2'd0;
    found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_ptr + 2'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt;
    last_ptr_d = last_ptr;
    idx_d      = gnt_idx;
    on_d       = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          state_d    = GRANT;
          idx_d      = winner;
          last_ptr_d = winner;
          hold_cnt_d = CNT_W'(1);
          on_d       = 1'b1;
        end
      end
      GRANT: begin
        // Release is tested first so a simultaneous drop never flags a timeout.
        if (!req[gnt_idx]) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else if (MAX_HOLD != 0 && hold_cnt == CNT_W'(MAX_HOLD)) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          timeout_d  = 1'b1;
        end else begin
          on_d = 1'b1;
          if (hold_cnt != {CNT_W{1'b1}}) hold_cnt_d = hold_cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  dec2to4 u_dec (
    .sel (idx_d),
    .en  (on_d),
    .y   (gnt_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_cnt  <= '0;
      last_ptr  <= 2'd3;
      gnt_idx   <= 2'd0;
      gnt       <= 4'b0000;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_cnt  <= hold_cnt_d;
      last_ptr  <= last_ptr_d;
      gnt_idx   <= idx_d;
      gnt       <= gnt_d;
      gnt_valid <= on_d;
      timeout   <= timeout_d;
    end
  end
endmodule

// File: tb/tb_rr_decode_arbiter4.sv
// Three arbiter builds (MAX_HOLD 16, 4, 0) checked every cycle against a reference model
// through an expected-value queue, plus directed reset and test-plan checks.
module tb_rr_decode_arbiter4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_a = '0, req_b = '0, req_c = '0;
  logic [3:0] gnt_a, gnt_b, gnt_c;
  logic [1:0] idx_a, idx_b, idx_c;
  logic       vld_a, vld_b, vld_c;
  logic       to_a, to_b, to_c;

  always #5 clk = ~clk;

  rr_decode_arbiter4 #(.MAX_HOLD(16), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(vld_a), .timeout(to_a));
  rr_decode_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(vld_b), .timeout(to_b));
  rr_decode_arbiter4 #(.MAX_HOLD(0), .CNT_W(8)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .req(req_c),
    .gnt(gnt_c), .gnt_idx(idx_c), .gnt_valid(vld_c), .timeout(to_c));

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] sb [$];

  int m_busy [3];
  int m_idx  [3];
  int m_last [3];
  int m_cnt  [3];
  int m_to   [3];
  int c_timeouts = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 0; m_idx[k] = 0; m_last[k] = 3; m_cnt[k] = 0; m_to[k] = 0;
    end
  endtask

  // Reference behaviour: output state after the coming rising edge.
  task automatic model_step(input int k, input int maxh, input logic [3:0] r);
    m_to[k] = 0;
    if (m_busy[k] == 0) begin
      if (r != 4'b0000) begin
        for (int j = 1; j <= 4; j++) begin
          int c;
          c = (m_last[k] + j) % 4;
          if (m_busy[k] == 0 && r[c]) begin
            m_busy[k] = 1; m_idx[k] = c; m_last[k] = c; m_cnt[k] = 1;
          end
        end
      end
    end else if (!r[m_idx[k]]) begin
      m_busy[k] = 0;
    end else if (maxh != 0 && m_cnt[k] == maxh) begin
      m_busy[k] = 0;
      m_to[k] = 1;
    end else if (m_cnt[k] < 255) begin
      m_cnt[k]++;
    end
  endtask

  function automatic logic [7:0] model_byte(input int k);
    logic [3:0] g;
    g = (m_busy[k] != 0) ? (4'b0001 << m_idx[k]) : 4'b0000;
    return {g, 2'(m_idx[k]), (m_busy[k] != 0), (m_to[k] != 0)};
  endfunction

  function automatic logic [23:0] observed();
    return {gnt_a, idx_a, vld_a, to_a, gnt_b, idx_b, vld_b, to_b, gnt_c, idx_c, vld_c, to_c};
  endfunction

  task automatic sample_and_drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    logic [23:0] o, e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      o = observed();
      check("dut_a", 32'(o[23:16]), 32'(e[23:16]));
      check("dut_b", 32'(o[15:8]),  32'(e[15:8]));
      check("dut_c", 32'(o[7:0]),   32'(e[7:0]));
    end
    req_a = a; req_b = b; req_c = c;
    model_step(0, 16, a);
    model_step(1, 4, b);
    model_step(2, 0, c);
    sb.push_back({model_byte(0), model_byte(1), model_byte(2)});
  endtask

  task automatic tick(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    @(negedge clk);
    sample_and_drive(a, b, c);
  endtask

  function automatic logic [3:0] wander(input logic [3:0] cur);
    return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : cur;
  endfunction

  logic [3:0] a_nxt, b_nxt, c_nxt;

  initial begin
    model_reset();
    #2;
    check("rst_gnt",     32'({gnt_a, gnt_b, gnt_c}), 32'h0);
    check("rst_idx",     32'({idx_a, idx_b, idx_c}), 32'h0);
    check("rst_vld_to",  32'({vld_a, vld_b, vld_c, to_a, to_b, to_c}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    a_nxt = '0; b_nxt = '0; c_nxt = '0;
    for (int n = 0; n < 400; n++) begin
      if      (n < 80)  a_nxt = 4'b1111;
      else if (n < 85)  a_nxt = 4'b0000;
      else if (n < 88)  a_nxt = 4'b0100;
      else if (n < 92)  a_nxt = 4'b0000;
      else if (n < 95)  a_nxt = 4'b0010;
      else if (n < 96)  a_nxt = 4'b0000;
      else if (n < 99)  a_nxt = 4'b0011;
      else if (n < 101) a_nxt = 4'b0000;
      else              a_nxt = wander(a_nxt);
      b_nxt = (n < 30) ? 4'b0010 : wander(b_nxt);
      c_nxt = (n < 300) ? 4'b1000 : wander(c_nxt);
      tick(a_nxt, b_nxt, c_nxt);
      if (n >= 2 && n < 301) begin
        if (to_c) c_timeouts++;
        check("c_hold_gnt", 32'(gnt_c), 32'h8);
      end
      if (n == 86) check("a_idx_after_0100", 32'(idx_a), 32'd2);
      if (n == 98) check("a_gnt_from_0011", 32'(gnt_a), 32'h1);
    end
    check("c_no_timeout", 32'(c_timeouts), 32'd0);

    for (int n = 0; n < 3; n++) tick(4'b0000, 4'b0000, 4'b0000);
    for (int n = 0; n < 3; n++) tick(4'b0100, 4'b0000, 4'b0000);
    check("a_gnt_before_rst", 32'(gnt_a), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'({gnt_a, gnt_b, gnt_c}), 32'h0);
    check("async_rst_vld", 32'({vld_a, vld_b, vld_c}), 32'h0);
    sb.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    sample_and_drive(4'b0110, 4'b0000, 4'b0000);
    tick(4'b0110, 4'b0000, 4'b0000);
    check("a_first_after_rst", 32'(gnt_a), 32'h2);
    for (int n = 0; n < 40; n++) tick(4'b0110, 4'b0000, 4'b0000);
    tick(4'b0000, 4'b0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
